// File: rtl/discus_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : discus_spi_pkg
//  Description : Shared constants for the discus snoop SPI link (op codes,
//                frame length).
//  Revision    : 1.0 - initial release
// ============================================================================
package discus_spi_pkg;

  // Command op codes carried in the first two bits of every frame
  localparam logic [1:0] SPI_OP_ADDR  = 2'b00;
  localparam logic [1:0] SPI_OP_PROG  = 2'b01;
  localparam logic [1:0] SPI_OP_READ  = 2'b10;
  localparam logic [1:0] SPI_OP_WRITE = 2'b11;

  // Frame = 2 op bits + 8 data bits
  localparam int SPI_FRAME_BITS = 10;

endpackage
`default_nettype wire

// File: rtl/swspi_master_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : sync2
//  Description : Two-flop synchroniser for the asynchronous miso line.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/swspi_master.sv
`default_nettype none
// ============================================================================
//  Module      : swspi_master
//  Description : Host-side initiator for the discus snoop SPI link. Sends one
//                10-bit frame (op + data) per accepted command and returns
//                the byte shifted in on miso.
//  Revision    : 1.0 - initial release
// ============================================================================
module swspi_master
  import discus_spi_pkg::*;
#(
  parameter int CLK_DIV = 8,   // SCK half-period in clk cycles (4..65535)
  parameter int GAP     = 16   // ssel-high cycles between frames (4..65535)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       sck,
  output logic       ssel,
  output logic       mosi,
  input  logic       miso
);

  // FSM encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(SPI_FRAME_BITS - 1);
  // The target only presents byte data from the third rising edge onwards
  localparam logic [3:0]  BIT_FIRST_CAP = 4'd2;

  logic [2:0]                state_q, state_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [3:0]                bit_q, bit_d;
  logic [SPI_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                      sck_q, sck_d;
  logic                      ssel_q, ssel_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [7:0]                rsp_q, rsp_d;
  logic                      miso_s;
  logic                      phase_done;
  logic                      gap_done;

  sync2 u_sync2 (
    .clk   (clk),
    .reset (reset),
    .d_i   (miso),
    .q_o   (miso_s)
  );

  assign phase_done = (cnt_q == DIV_LAST);
  assign gap_done   = (cnt_q == GAP_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: each phase lasts CLK_DIV cycles, the gap lasts GAP
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid)  state_d = S_SETUP;
      S_SETUP: if (phase_done) state_d = S_HIGH;
      S_HIGH:  if (phase_done) state_d = (bit_q == BIT_LAST) ? S_HOLD : S_LOW;
      S_LOW:   if (phase_done) state_d = S_HIGH;
      S_HOLD:  if (phase_done) state_d = S_GAP;
      S_GAP:   if (gap_done)   state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Output/datapath decode: SCK edges, bit shifting and miso capture
  always_comb begin
    cnt_d       = (state_q == S_IDLE || state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    sck_d       = sck_q;
    ssel_d      = ssel_q;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          shreg_d = {cmd_op, cmd_data};
          bit_d   = 4'd0;
          sck_d   = 1'b0;
          ssel_d  = 1'b0;
        end
      end
      S_SETUP, S_LOW: begin
        if (phase_done) begin
          sck_d = 1'b1;
          if (bit_q >= BIT_FIRST_CAP) begin
            rsp_d = {rsp_q[6:0], miso_s};
          end
        end
      end
      S_HIGH: begin
        if (phase_done) begin
          sck_d = 1'b0;
          // After the last fall mosi keeps the final bit until the next accept
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + 4'd1;
            shreg_d = {shreg_q[SPI_FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      S_HOLD: begin
        if (phase_done) begin
          ssel_d      = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= 16'd0;
      bit_q       <= 4'd0;
      shreg_q     <= '0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= 8'h00;
    end else begin
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      sck_q       <= sck_d;
      ssel_q      <= ssel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign sck       = sck_q;
  assign ssel      = ssel_q;
  assign mosi      = shreg_q[SPI_FRAME_BITS-1];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q;

endmodule
`default_nettype wire

// File: tb/tb_swspi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_swspi_master
//  Description : Bench for swspi_master: two DUT instances (default and fast
//                timing) sharing one bit-sampled SPI target model, with a
//                command-level reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_swspi_master;
  import discus_spi_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] cmd_valid = 2'b00;
  logic [1:0] cmd_ready, busy, sck, ssel, mosi, rsp_valid;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] rsp_data0, rsp_data1;
  logic       miso;
  logic       sel = 1'b0;       // which DUT is wired to the target
  logic       slow_tgt = 1'b0;  // target answers 3 cycles late
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  swspi_master #(.CLK_DIV(8), .GAP(16)) u_dut0 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data0),
    .busy(busy[0]), .sck(sck[0]), .ssel(ssel[0]), .mosi(mosi[0]), .miso(miso)
  );

  swspi_master #(.CLK_DIV(4), .GAP(4)) u_dut1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data1),
    .busy(busy[1]), .sck(sck[1]), .ssel(ssel[1]), .mosi(mosi[1]), .miso(miso)
  );

  logic       t_sck, t_ssel, t_mosi, t_rdy, t_rv;
  logic [7:0] t_rsp;
  assign t_sck  = sck[sel];
  assign t_ssel = ssel[sel];
  assign t_mosi = mosi[sel];
  assign t_rdy  = cmd_ready[sel];
  assign t_rv   = rsp_valid[sel];
  assign t_rsp  = sel ? rsp_data1 : rsp_data0;

  function automatic logic [7:0] init_byte(input logic [7:0] a);
    return (a == 8'h3C) ? 8'hA5 : ((a * 8'd7 + 8'd3) ^ 8'h5A);
  endfunction

  // ---------------- SPI target model ----------------
  logic [7:0] tgt_mem [256];
  logic [7:0] tgt_addr = 8'h00;
  logic [7:0] tgt_shift = 8'h00;
  logic [9:0] tgt_frame = '0;
  int         tgt_cnt = 0;
  logic       tgt_drive = 1'b0;
  logic [2:0] tgt_pipe = 3'b000;
  logic       tgt_init = 1'b0;
  logic [9:0] last_frame = '0;
  int         last_cnt = 0;
  logic       tp_sck = 1'b0, tp_ssel = 1'b1;

  // Target samples mosi on SCK rise, answers 0 then the byte MSB first, commits on ssel rise
  always @(negedge clk) begin
    if (tgt_init) begin
      for (int a = 0; a < 256; a++) tgt_mem[a] <= init_byte(8'(a));
    end
    if (tp_ssel === 1'b1 && t_ssel === 1'b0) begin
      tgt_cnt   <= 0;
      tgt_frame <= '0;
      tgt_shift <= tgt_mem[tgt_addr];
    end else if (t_ssel === 1'b0 && tp_sck === 1'b0 && t_sck === 1'b1) begin
      tgt_frame <= {tgt_frame[8:0], t_mosi};
      tgt_cnt   <= tgt_cnt + 1;
      if (tgt_cnt >= 1 && tgt_cnt <= 8) begin
        tgt_drive <= tgt_shift[7];
        tgt_shift <= {tgt_shift[6:0], 1'b0};
      end else begin
        tgt_drive <= 1'b0;
      end
    end
    if (tp_ssel === 1'b0 && t_ssel === 1'b1) begin
      last_frame <= tgt_frame;
      last_cnt   <= tgt_cnt;
      if (tgt_cnt == 10) begin
        case (tgt_frame[9:8])
          SPI_OP_ADDR:  tgt_addr <= tgt_frame[7:0];
          SPI_OP_WRITE: begin
            tgt_mem[tgt_addr] <= tgt_frame[7:0];
            tgt_addr <= tgt_addr + 8'd1;
          end
          default:      tgt_addr <= tgt_addr + 8'd1;
        endcase
      end
    end
    tgt_pipe <= {tgt_pipe[1:0], tgt_drive};
    tp_sck   <= t_sck;
    tp_ssel  <= t_ssel;
  end

  assign miso = slow_tgt ? tgt_pipe[2] : tgt_drive;

  // ---------------- event monitor ----------------
  int         ev_fall = 0, ev_srise = 0, ev_rspv = 0, ev_rdy = 0, gap_meas = 0;
  int         rise_cyc [10];
  logic [3:0] nrise = 4'd0;
  int         nfall = 0, nrspv = 0;
  logic [7:0] rsp_cap = 8'h00;
  logic       mp_sck = 1'b0, mp_ssel = 1'b1, mp_rdy = 1'b1;

  // Record cycle numbers of the selected DUT's interface events
  always @(negedge clk) begin
    if (mp_ssel === 1'b1 && t_ssel === 1'b0) begin
      ev_fall  <= cyc;
      gap_meas <= cyc - ev_srise;
      nrise    <= 4'd0;
      nfall    <= nfall + 1;
    end else if (mp_sck === 1'b0 && t_sck === 1'b1 && nrise < 4'd10) begin
      rise_cyc[nrise] <= cyc;
      nrise <= nrise + 4'd1;
    end
    if (mp_ssel === 1'b0 && t_ssel === 1'b1) ev_srise <= cyc;
    if (t_rv === 1'b1) begin
      ev_rspv <= cyc;
      nrspv   <= nrspv + 1;
      rsp_cap <= t_rsp;
    end
    if (mp_rdy === 1'b0 && t_rdy === 1'b1) ev_rdy <= cyc;
    mp_sck  <= t_sck;
    mp_ssel <= t_ssel;
    mp_rdy  <= t_rdy;
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  logic [7:0] ref_addr = 8'h00;

  task automatic ref_apply(input logic [1:0] op, input logic [7:0] data, output logic [7:0] exp);
    exp = ref_mem[ref_addr];
    case (op)
      SPI_OP_ADDR:  ref_addr = data;
      SPI_OP_WRITE: begin
        ref_mem[ref_addr] = data;
        ref_addr = ref_addr + 8'd1;
      end
      default:      ref_addr = ref_addr + 8'd1;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int dval();
    return sel ? 4 : 8;
  endfunction

  function automatic int gval();
    return sel ? 4 : 16;
  endfunction

  // Called at a negedge with cmd_valid already high; returns just after the accept edge
  task automatic wait_accept(output int acc);
    acc = -1;
    for (int t = 0; t < 3000; t++) begin
      if (t_rdy === 1'b1) begin
        acc = cyc + 1;
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data, output int acc, output logic ok);
    int n0;
    int t;
    ok = 1'b1;
    cmd_op = op;
    cmd_data = data;
    cmd_valid[sel] = 1'b1;
    wait_accept(acc);
    cmd_valid[sel] = 1'b0;
    cmd_op = 2'($urandom);
    cmd_data = 8'($urandom);
    if (acc < 0) ok = 1'b0;
    n0 = nrspv;
    t = 0;
    while (nrspv == n0 && t < 3000) begin @(negedge clk); t++; end
    if (nrspv == n0) ok = 1'b0;
    t = 0;
    while (t_rdy !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    if (t_rdy !== 1'b1) ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_timing(input int acc);
    int d;
    int g;
    d = dval();
    g = gval();
    chk("t_ssel_fall", ev_fall - acc, 0);
    chk("t_nrise", 32'(nrise), 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("t_rise%0d", k), rise_cyc[k] - acc, d + 2 * k * d);
    chk("t_ssel_rise", ev_srise - acc, 21 * d);
    chk("t_rsp_valid", ev_rspv - acc, 21 * d);
    chk("t_cmd_ready", ev_rdy - acc, 21 * d + g);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data);
    logic [7:0] exp;
    int acc;
    logic ok;
    ref_apply(op, data, exp);
    do_cmd(op, data, acc, ok);
    chk("cmd_done", 32'(ok), 1);
    chk("frame_bits", 32'(last_frame), 32'({op, data}));
    chk("frame_len", last_cnt, 10);
    if (op == SPI_OP_READ) chk("read_data", 32'(rsp_cap), 32'(exp));
    chk("tgt_addr", 32'(tgt_addr), 32'(ref_addr));
    chk_timing(acc);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a1;
    int a2;
    int t;
    int nf0;
    logic [7:0] e8;
    logic [7:0] w;

    reset = 1'b1;
    tgt_init = 1'b1;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_byte(8'(a));
    ref_addr = 8'h00;
    repeat (3) @(negedge clk);
    tgt_init = 1'b0;
    reset = 1'b0;
    repeat (50) @(negedge clk);

    // Reset / idle state
    chk("rst_ssel", 32'(ssel), 32'(2'b11));
    chk("rst_sck", 32'(sck), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_ready", 32'(cmd_ready), 32'(2'b11));
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_data", 32'(rsp_data0), 0);
    chk("rst_no_rsp_valid", nrspv, 0);

    // Address load, then reads with auto-increment
    run_cmd(SPI_OP_ADDR, 8'h3C);
    chk("addr_3c", 32'(tgt_addr), 32'h3C);
    run_cmd(SPI_OP_READ, 8'h00);
    chk("read_a5", 32'(rsp_cap), 32'hA5);
    run_cmd(SPI_OP_READ, 8'hFF);

    // Back-to-back writes with cmd_valid held across the gap
    run_cmd(SPI_OP_ADDR, 8'h10);
    nf0 = nfall;
    ref_apply(SPI_OP_WRITE, 8'h5A, e8);
    ref_apply(SPI_OP_WRITE, 8'hC3, e8);
    cmd_op = SPI_OP_WRITE;
    cmd_data = 8'h5A;
    cmd_valid[0] = 1'b1;
    wait_accept(a1);
    cmd_data = 8'hC3;
    wait_accept(a2);
    cmd_valid[0] = 1'b0;
    t = 0;
    while (t_rdy !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("b2b_accept_spacing", a2 - a1, 21 * 8 + 16 + 1);
    chk("b2b_gap", gap_meas, 16 + 1);
    chk("b2b_frames", nfall - nf0, 2);
    chk("b2b_mem10", 32'(tgt_mem[8'h10]), 32'h5A);
    chk("b2b_mem11", 32'(tgt_mem[8'h11]), 32'hC3);

    // Random command mix on the default-timing instance
    for (int i = 0; i < 10; i++) run_cmd(2'($urandom_range(0, 3)), 8'($urandom));

    // Fast instance with a slow-answering target
    sel = 1'b1;
    slow_tgt = 1'b1;
    repeat (4) @(negedge clk);
    a1 = $urandom_range(0, 255);
    w  = 8'($urandom);
    run_cmd(SPI_OP_ADDR, 8'(a1));
    run_cmd(SPI_OP_WRITE, w);
    run_cmd(SPI_OP_ADDR, 8'(a1));
    run_cmd(SPI_OP_READ, 8'h00);
    chk("fast_readback", 32'(rsp_cap), 32'(w));
    for (int i = 0; i < 10; i++) run_cmd(2'($urandom_range(0, 3)), 8'($urandom));

    // Reset in the middle of a write frame
    sel = 1'b0;
    slow_tgt = 1'b0;
    repeat (4) @(negedge clk);
    cmd_op = SPI_OP_WRITE;
    cmd_data = 8'($urandom);
    cmd_valid[0] = 1'b1;
    wait_accept(a1);
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    t = 0;
    while (nrise < 4'd6 && t < 500) begin @(negedge clk); t++; end
    chk("rst_mid_reached_rise5", 32'(nrise), 6);
    reset = 1'b1;
    #1;
    chk("rst_mid_ssel", 32'(ssel[0]), 1);
    chk("rst_mid_sck", 32'(sck[0]), 0);
    chk("rst_mid_ready", 32'(cmd_ready[0]), 1);
    chk("rst_mid_busy", 32'(busy[0]), 0);
    chk("rst_mid_rsp_data", 32'(rsp_data0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    a1 = $urandom_range(0, 255);
    run_cmd(SPI_OP_ADDR, 8'(a1));
    run_cmd(SPI_OP_READ, 8'h00);
    run_cmd(SPI_OP_READ, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
